param_register_file: RTL and testbench

- Parametrised successor to the CPU's 16x16 register file: NREGS words of WIDTH bits, two addressed read ports (A, B) plus a dedicated PC read port.
- Port A loads from DIN. Port B does increment/decrement with a selectable step and reports wrap-around.
- The PC register auto-advances every enabled cycle, with defined priority against explicit loads and inc/dec.
- Sits between the instruction decoder (drives the X controls) and the ALU/address bus (consumes the DOUT_* ports).

---
 rtl/param_register_file_pkg.sv | 27 ++
 rtl/param_register_file_if.sv | 32 +++
 rtl/param_register_file_reg_cell.sv | 45 ++++
 rtl/param_register_file.sv | 66 ++++++
 tb/tb_param_register_file.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/param_register_file_pkg.sv
// Shared encodings and defaults for the parametrised register file.
// REGBOPX bit meanings, step encoding and the default geometry live here.
package param_register_file_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_NREGS = 16;

    localparam int INCDEC_EN_BIT = 0;
    localparam int INCDEC_UP_BIT = 1;

    typedef enum logic {
        STEP_ONE = 1'b0,
        STEP_TWO = 1'b1
    } step_e;

    function automatic logic [1:0] step_amount(input logic sel);
        logic [1:0] amt;
        amt = 2'd1;
        case (step_e'(sel))
            STEP_ONE: amt = 2'd1;
            STEP_TWO: amt = 2'd2;
            default:  amt = 2'd1;
        endcase
        return amt;
    endfunction

endpackage

// File: rtl/param_register_file_if.sv
// Decoder-to-register-file bus: control fields in, read ports and wrap flag out.
// No handshake: controls are sampled on every enabled rising edge, reads are combinational.
interface param_register_file_if #(
    parameter int WIDTH = 16,
    parameter int NREGS = 16
);
    localparam int AW = $clog2(NREGS);

    logic             EN;
    logic [WIDTH-1:0] DIN;
    logic [AW-1:0]    REGAX;
    logic [AW-1:0]    REGBX;
    logic             REGAOPX;
    logic [1:0]       REGBOPX;
    logic             REGBSTEPX;
    logic             PC_HOLDX;
    logic [WIDTH-1:0] DOUT_A;
    logic [WIDTH-1:0] DOUT_B;
    logic [WIDTH-1:0] DOUT_PC;
    logic             WRAPX;

    modport master (
        output EN, DIN, REGAX, REGBX, REGAOPX, REGBOPX, REGBSTEPX, PC_HOLDX,
        input  DOUT_A, DOUT_B, DOUT_PC, WRAPX
    );

    modport slave (
        input  EN, DIN, REGAX, REGBX, REGAOPX, REGBOPX, REGBSTEPX, PC_HOLDX,
        output DOUT_A, DOUT_B, DOUT_PC, WRAPX
    );

endinterface

// File: rtl/param_register_file_reg_cell.sv
// One register of the file: load > inc/dec > auto-increment > hold.
// The wrap output flags a carry/borrow from an inc/dec that was not overridden by a load.
module param_register_file_reg_cell
    import param_register_file_pkg::*;
#(
    parameter int               WIDTH     = 16,
    parameter int               PC_STEP   = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             incdec,
    input  logic             up,
    input  logic             step_sel,
    input  logic             auto_inc,
    output logic [WIDTH-1:0] q,
    output logic             wrap
);

    logic [WIDTH:0] step_ext;
    logic [WIDTH:0] ext_res;

    // One extra bit captures carry on increment and borrow on decrement.
    assign step_ext = (WIDTH+1)'(step_amount(step_sel));
    assign ext_res  = up ? ({1'b0, q} + step_ext) : ({1'b0, q} - step_ext);
    assign wrap     = incdec & ~load & ext_res[WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RESET_VAL;
        end else if (en) begin
            if (load) begin
                q <= din;
            end else if (incdec) begin
                q <= ext_res[WIDTH-1:0];
            end else if (auto_inc) begin
                q <= q + WIDTH'(PC_STEP);
            end
        end
    end

endmodule

// File: rtl/param_register_file.sv
// NREGS x WIDTH register file with load port A, inc/dec port B and an auto-advancing PC.
// Decodes addresses into per-cell enables, muxes the read ports and registers WRAPX.
module param_register_file
    import param_register_file_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int NREGS    = DEFAULT_NREGS,
    parameter int PC_INDEX = NREGS - 1,
    parameter int PC_STEP  = 1,
    parameter int RESET_PC = 0
) (
    input logic                CLK,
    input logic                RESET,
    param_register_file_if.slave bus
);

    localparam int AW = $clog2(NREGS);

    logic [WIDTH-1:0] regs [NREGS];
    logic [NREGS-1:0] wraps;

    for (genvar i = 0; i < NREGS; i++) begin : g_cell
        localparam logic [WIDTH-1:0] CELL_RESET = (i == PC_INDEX) ? WIDTH'(RESET_PC) : '0;
        localparam bit               IS_PC      = (i == PC_INDEX);

        logic load_sel;
        logic incdec_sel;
        logic auto_sel;

        assign load_sel   = bus.REGAOPX && (bus.REGAX == AW'(i));
        assign incdec_sel = bus.REGBOPX[INCDEC_EN_BIT] && (bus.REGBX == AW'(i));
        assign auto_sel   = IS_PC && !bus.PC_HOLDX;

        param_register_file_reg_cell #(
            .WIDTH    (WIDTH),
            .PC_STEP  (PC_STEP),
            .RESET_VAL(CELL_RESET)
        ) u_cell (
            .clk     (CLK),
            .rst     (RESET),
            .en      (bus.EN),
            .load    (load_sel),
            .din     (bus.DIN),
            .incdec  (incdec_sel),
            .up      (bus.REGBOPX[INCDEC_UP_BIT]),
            .step_sel(bus.REGBSTEPX),
            .auto_inc(auto_sel),
            .q       (regs[i]),
            .wrap    (wraps[i])
        );
    end

    assign bus.DOUT_A  = regs[bus.REGAX];
    assign bus.DOUT_B  = regs[bus.REGBX];
    assign bus.DOUT_PC = regs[PC_INDEX];

    // At most one cell can be the inc/dec target, so OR-reducing is exact.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            bus.WRAPX <= 1'b0;
        end else if (bus.EN) begin
            bus.WRAPX <= |wraps;
        end
    end

endmodule

// File: tb/tb_param_register_file.sv
// Directed bench for param_register_file: default geometry plus an 8-bit, 4-register build.
module tb_param_register_file;

  logic CLK;
  logic RESET;
  int   n_cmp;
  int   n_mis;

  param_register_file_if #(.WIDTH(16), .NREGS(16)) bus0 ();
  param_register_file_if #(.WIDTH(8),  .NREGS(4))  bus1 ();

  param_register_file #(
    .WIDTH(16), .NREGS(16), .PC_INDEX(15), .PC_STEP(1), .RESET_PC(0)
  ) dut0 (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus0.slave)
  );

  param_register_file #(
    .WIDTH(8), .NREGS(4), .PC_INDEX(3), .PC_STEP(2), .RESET_PC(16)
  ) dut1 (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus1.slave)
  );

  // clock / reset
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // driver tasks
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle0();
    bus0.EN        = 1'b1;
    bus0.DIN       = '0;
    bus0.REGAOPX   = 1'b0;
    bus0.REGBOPX   = 2'b00;
    bus0.REGBSTEPX = 1'b0;
    bus0.PC_HOLDX  = 1'b0;
  endtask

  task automatic idle1();
    bus1.DIN       = '0;
    bus1.REGAOPX   = 1'b0;
    bus1.REGBOPX   = 2'b00;
    bus1.REGBSTEPX = 1'b0;
    bus1.PC_HOLDX  = 1'b0;
  endtask

  task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    n_cmp++;
    assert (observed === expected) else begin
      n_mis++;
      $error("FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_mis = 0;
    RESET = 1'b0;
    idle0();
    bus0.REGAX = 4'd0;
    bus0.REGBX = 4'd3;
    idle1();
    bus1.EN    = 1'b0;
    bus1.REGAX = 2'd0;
    bus1.REGBX = 2'd0;

    // reset then free-running PC
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    check("rst_pc", bus0.DOUT_PC, 16'h0000);
    check("rst_wrap", {15'd0, bus0.WRAPX}, 16'h0000);
    check("rst_a", bus0.DOUT_A, 16'h0000);
    check("rst_b", bus0.DOUT_B, 16'h0000);
    tick();
    check("pc_1", bus0.DOUT_PC, 16'h0001);
    tick();
    check("pc_2", bus0.DOUT_PC, 16'h0002);
    tick();
    check("pc_3", bus0.DOUT_PC, 16'h0003);
    check("idle_wrap", {15'd0, bus0.WRAPX}, 16'h0000);

    // load r3 = FFFF, then inc by 1 (wraps), dec by 2 (wraps), idle
    bus0.REGAX = 4'd3; bus0.DIN = 16'hFFFF; bus0.REGAOPX = 1'b1;
    tick();
    idle0();
    check("load_r3", bus0.DOUT_A, 16'hFFFF);
    bus0.REGBX = 4'd3; bus0.REGBOPX = 2'b11; bus0.REGBSTEPX = 1'b0;
    tick();
    check("inc_wrap_val", bus0.DOUT_B, 16'h0000);
    check("inc_wrap_flag", {15'd0, bus0.WRAPX}, 16'h0001);
    bus0.REGBOPX = 2'b01; bus0.REGBSTEPX = 1'b1;
    tick();
    check("dec2_wrap_val", bus0.DOUT_B, 16'hFFFE);
    check("dec2_wrap_flag", {15'd0, bus0.WRAPX}, 16'h0001);
    idle0();
    tick();
    check("idle_clears_wrap", {15'd0, bus0.WRAPX}, 16'h0000);
    check("r3_held", bus0.DOUT_B, 16'hFFFE);
    check("pc_7", bus0.DOUT_PC, 16'h0007);
    bus0.REGBOPX = 2'b11;
    tick();
    check("inc_nowrap_val", bus0.DOUT_B, 16'hFFFF);
    check("inc_nowrap_flag", {15'd0, bus0.WRAPX}, 16'h0000);

    // set WRAPX, then a same-register collision must clear it and keep the load
    tick();
    check("prewrap_val", bus0.DOUT_B, 16'h0000);
    check("prewrap_flag", {15'd0, bus0.WRAPX}, 16'h0001);
    bus0.REGAX = 4'd5; bus0.REGBX = 4'd5; bus0.REGAOPX = 1'b1; bus0.DIN = 16'h1234;
    bus0.REGBOPX = 2'b11; bus0.REGBSTEPX = 1'b0;
    tick();
    check("collide_a", bus0.DOUT_A, 16'h1234);
    check("collide_b", bus0.DOUT_B, 16'h1234);
    check("collide_wrap", {15'd0, bus0.WRAPX}, 16'h0000);

    // load and inc/dec on different registers in one cycle
    bus0.REGAX = 4'd2; bus0.DIN = 16'h00AA; bus0.REGAOPX = 1'b1;
    bus0.REGBX = 4'd5; bus0.REGBOPX = 2'b11; bus0.REGBSTEPX = 1'b1;
    tick();
    idle0();
    check("dual_load", bus0.DOUT_A, 16'h00AA);
    check("dual_inc", bus0.DOUT_B, 16'h1236);

    // PC priority: load beats auto-inc, B dec replaces it, hold freezes it
    bus0.REGAX = 4'd15; bus0.DIN = 16'h0100; bus0.REGAOPX = 1'b1;
    tick();
    idle0();
    check("pc_load", bus0.DOUT_PC, 16'h0100);
    bus0.REGBX = 4'd15; bus0.REGBOPX = 2'b01; bus0.REGBSTEPX = 1'b1;
    tick();
    idle0();
    check("pc_dec2", bus0.DOUT_PC, 16'h00FE);
    bus0.PC_HOLDX = 1'b1;
    tick();
    check("pc_hold", bus0.DOUT_PC, 16'h00FE);
    bus0.PC_HOLDX = 1'b0;
    tick();
    check("pc_resume", bus0.DOUT_PC, 16'h00FF);

    // PC wrap through auto-increment never raises WRAPX
    bus0.REGAX = 4'd15; bus0.DIN = 16'hFFFF; bus0.REGAOPX = 1'b1;
    tick();
    idle0();
    tick();
    check("pc_autowrap", bus0.DOUT_PC, 16'h0000);
    check("pc_autowrap_flag", {15'd0, bus0.WRAPX}, 16'h0000);

    // stall: set WRAPX first, then EN=0 with pending ops
    bus0.REGBX = 4'd3; bus0.REGBOPX = 2'b01; bus0.REGBSTEPX = 1'b0;
    tick();
    check("r3_dec_wrap", bus0.DOUT_B, 16'hFFFF);
    check("pc_pre_stall", bus0.DOUT_PC, 16'h0001);
    bus0.EN = 1'b0;
    bus0.REGAX = 4'd2; bus0.DIN = 16'hAAAA; bus0.REGAOPX = 1'b1;
    bus0.REGBX = 4'd4; bus0.REGBOPX = 2'b11;
    tick();
    check("stall_a", bus0.DOUT_A, 16'h00AA);
    check("stall_b", bus0.DOUT_B, 16'h0000);
    check("stall_wrap", {15'd0, bus0.WRAPX}, 16'h0001);
    check("stall_pc", bus0.DOUT_PC, 16'h0001);
    bus0.REGAX = 4'd5;
    #1;
    check("stall_live_read", bus0.DOUT_A, 16'h1236);

    // reset with pending ops
    bus0.EN = 1'b1;
    bus0.REGAX = 4'd2; bus0.DIN = 16'hAAAA; bus0.REGAOPX = 1'b1;
    bus0.REGBX = 4'd4; bus0.REGBOPX = 2'b11;
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    idle0();
    check("midrst_a", bus0.DOUT_A, 16'h0000);
    check("midrst_b", bus0.DOUT_B, 16'h0000);
    check("midrst_pc", bus0.DOUT_PC, 16'h0000);
    check("midrst_wrap", {15'd0, bus0.WRAPX}, 16'h0000);
    bus0.REGAX = 4'd5;
    #1;
    check("midrst_r5", bus0.DOUT_A, 16'h0000);

    // narrow build: 8-bit, 4 regs, PC step 2, reset PC 0x10
    bus1.EN = 1'b1;
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    check("n_rst_pc", {8'd0, bus1.DOUT_PC}, 16'h0010);
    tick();
    check("n_pc_12", {8'd0, bus1.DOUT_PC}, 16'h0012);
    bus1.REGAX = 2'd1; bus1.DIN = 8'hFF; bus1.REGAOPX = 1'b1;
    tick();
    idle1();
    check("n_pc_14", {8'd0, bus1.DOUT_PC}, 16'h0014);
    check("n_load_r1", {8'd0, bus1.DOUT_A}, 16'h00FF);
    bus1.REGBX = 2'd1; bus1.REGBOPX = 2'b11;
    tick();
    idle1();
    check("n_inc_wrap_val", {8'd0, bus1.DOUT_B}, 16'h0000);
    check("n_inc_wrap_flag", {15'd0, bus1.WRAPX}, 16'h0001);
    check("n_pc_16", {8'd0, bus1.DOUT_PC}, 16'h0016);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
